mips_register_file: RTL and testbench

Architectural register file of the single-cycle MIPS32 datapath, sitting directly upstream of the 32-bit ALU. It holds the 32 general-purpose registers and supplies the two ALU operands, `a` from `read_data1` and `b` from `read_data2`, combinationally from the instruction's rs/rt fields. It accepts one write-back per clock, either the ALU result or memory data selected upstream by the write-back mux. Register `$0` is hardwired to zero, and an optional write-to-read bypass lets a consumer see the value being written in the same cycle.

---
 rtl/mips_register_file.sv | 79 +++++++
 tb/tb_mips_register_file.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mips_register_file.sv
// Architectural register file for the single-cycle MIPS32 datapath: 31 stored GPRs,
// hardwired $0, two combinational read ports with optional write-to-read bypass.
module mips_register_file #(
    parameter bit          BYPASS    = 1'b1,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  read_reg1,
    input  logic [4:0]  read_reg2,
    input  logic [4:0]  write_reg,
    input  logic [31:0] write_data,
    input  logic        reg_write,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    output logic        zero_write_attempt
);

    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];
    logic        zero_write_attempt_q;
    logic        zero_write_attempt_d;
    logic        bypass_en;
    logic [31:0] stored1;
    logic [31:0] stored2;

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < 32; i++) begin
            if (reg_write && (write_reg == 5'(i))) begin
                regs_d[i] = write_data;
            end
        end
        zero_write_attempt_d = reg_write && (write_reg == 5'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            zero_write_attempt_q <= 1'b0;
        end else begin
            regs_q               <= regs_d;
            zero_write_attempt_q <= zero_write_attempt_d;
        end
    end

    // Bypass is gated by rst_n so a write held during reset never leaks to the readers.
    assign bypass_en = BYPASS && rst_n && reg_write;

    always_comb begin
        stored1 = 32'h0;
        stored2 = 32'h0;
        for (int i = 1; i < 32; i++) begin
            if (read_reg1 == 5'(i)) stored1 = regs_q[i];
            if (read_reg2 == 5'(i)) stored2 = regs_q[i];
        end

        if (read_reg1 == 5'd0) begin
            read_data1 = 32'h0;
        end else if (bypass_en && (write_reg == read_reg1)) begin
            read_data1 = write_data;
        end else begin
            read_data1 = stored1;
        end

        if (read_reg2 == 5'd0) begin
            read_data2 = 32'h0;
        end else if (bypass_en && (write_reg == read_reg2)) begin
            read_data2 = write_data;
        end else begin
            read_data2 = stored2;
        end
    end

    assign zero_write_attempt = zero_write_attempt_q;

endmodule

// File: tb/tb_mips_register_file.sv
// Bench for mips_register_file: two instances (bypass on/off) share stimulus and are checked
// against an array model every cycle, plus directed literal expectations.
module tb_mips_register_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  read_reg1 = 5'd0;
    logic [4:0]  read_reg2 = 5'd0;
    logic [4:0]  write_reg = 5'd0;
    logic [31:0] write_data = 32'h0;
    logic        reg_write = 1'b0;

    logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
    logic        b_zwa, n_zwa;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [32];
    bit          exp_zwa = 1'b0;
    bit          model_valid = 1'b0;

    always #5 clk = ~clk;

    mips_register_file #(.BYPASS(1'b1), .RESET_VAL(32'h0)) u_byp (
        .clk(clk), .rst_n(rst_n), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .read_data1(b_rd1), .read_data2(b_rd2), .zero_write_attempt(b_zwa)
    );

    mips_register_file #(.BYPASS(1'b0), .RESET_VAL(32'h0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .read_data1(n_rd1), .read_data2(n_rd2), .zero_write_attempt(n_zwa)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit byp);
        if (idx == 5'd0) return 32'h0;
        if (byp && rst_n && reg_write && write_reg == idx) return write_data;
        return mem[idx];
    endfunction

    // Architectural model: reset clears everything, a clock edge commits one write.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
            exp_zwa     = 1'b0;
            model_valid = 1'b1;
        end else begin
            exp_zwa = reg_write && (write_reg == 5'd0);
            if (reg_write && write_reg != 5'd0) mem[write_reg] = write_data;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check32("byp_rd1",   b_rd1, exp_read(read_reg1, 1'b1));
            check32("byp_rd2",   b_rd2, exp_read(read_reg2, 1'b1));
            check32("nobyp_rd1", n_rd1, exp_read(read_reg1, 1'b0));
            check32("nobyp_rd2", n_rd2, exp_read(read_reg2, 1'b0));
            check32("byp_zwa",   {31'h0, b_zwa}, {31'h0, exp_zwa});
            check32("nobyp_zwa", {31'h0, n_zwa}, {31'h0, exp_zwa});
        end
    end

    // Inputs change 1 time unit after each rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] data);
        reg_write  = 1'b1;
        write_reg  = idx;
        write_data = data;
        cyc();
        reg_write  = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Reset pulse between edges clears storage and a pending zero-write flag.
        wr(5'd7, 32'hAAAA_5555);
        wr(5'd0, 32'h0000_0001);
        read_reg1 = 5'd7;
        #1 check32("zwa_set_before_reset", {31'h0, b_zwa}, 32'h1);
        rst_n = 1'b0;
        #1 check32("zwa_cleared_by_reset", {31'h0, b_zwa}, 32'h0);
        check32("r7_cleared_by_reset", b_rd1, 32'h0);
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(31 - i);
            #1;
            check32("reset_scan_p1", b_rd1, 32'h0);
            check32("reset_scan_p2", n_rd2, 32'h0);
            cyc();
        end

        // Write and read back.
        wr(5'd5, 32'hDEAD_BEEF);
        wr(5'd31, 32'h0000_0007);
        read_reg1 = 5'd5;
        read_reg2 = 5'd31;
        #1;
        check32("r5_readback", n_rd1, 32'hDEAD_BEEF);
        check32("r31_readback", n_rd2, 32'h0000_0007);
        read_reg1 = 5'd6;
        #1 check32("r6_unwritten", b_rd1, 32'h0);
        cyc();

        // $0 immunity: no bypass leak, flag for exactly one cycle.
        read_reg1  = 5'd0;
        read_reg2  = 5'd0;
        reg_write  = 1'b1;
        write_reg  = 5'd0;
        write_data = 32'hFFFF_FFFF;
        #1;
        check32("r0_p1_during_write", b_rd1, 32'h0);
        check32("r0_p2_during_write", b_rd2, 32'h0);
        cyc();
        reg_write = 1'b0;
        #1 check32("zwa_one_cycle", {31'h0, b_zwa}, 32'h1);
        cyc();
        #1 check32("zwa_cleared", {31'h0, n_zwa}, 32'h0);

        // Bypass vs no bypass on a same-cycle read/write of r9.
        wr(5'd9, 32'h1111_1111);
        read_reg1  = 5'd9;
        read_reg2  = 5'd9;
        reg_write  = 1'b1;
        write_reg  = 5'd9;
        write_data = 32'h2222_2222;
        #1;
        check32("byp_p1_same_cycle", b_rd1, 32'h2222_2222);
        check32("byp_p2_same_cycle", b_rd2, 32'h2222_2222);
        check32("nobyp_p1_old", n_rd1, 32'h1111_1111);
        check32("nobyp_p2_old", n_rd2, 32'h1111_1111);
        cyc();
        reg_write = 1'b0;
        #1;
        check32("nobyp_p1_new", n_rd1, 32'h2222_2222);
        check32("nobyp_p2_new", n_rd2, 32'h2222_2222);

        // Write enable low holds r3.
        wr(5'd3, 32'h0000_0033);
        read_reg1  = 5'd3;
        write_reg  = 5'd3;
        write_data = 32'hABCD_0000;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check32("r3_held_byp", b_rd1, 32'h0000_0033);
            check32("r3_held_nobyp", n_rd1, 32'h0000_0033);
        end

        // Reset arriving with a write pending: reset wins, write after release succeeds.
        wr(5'd12, 32'h5A5A_5A5A);
        read_reg1  = 5'd12;
        read_reg2  = 5'd12;
        reg_write  = 1'b1;
        write_reg  = 5'd12;
        write_data = 32'h1234_5678;
        rst_n      = 1'b0;
        #1;
        check32("r12_reset_immediate", b_rd1, 32'h0);
        check32("r12_reset_immediate_p2", b_rd2, 32'h0);
        cyc();
        check32("r12_reset_after_edge", n_rd1, 32'h0);
        #1 rst_n = 1'b1;
        cyc();
        reg_write = 1'b0;
        #1;
        check32("r12_write_after_reset", n_rd1, 32'h1234_5678);
        check32("alu_add_r12_r12", n_rd1 + n_rd2, 32'h2468_ACF0);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
